// File: rtl/cfm_uart.sv
// Byte-oriented 8N1 UART for the CFM core: a TX shift engine with a valid/ready handshake,
// and an RX engine with a mid-bit sampler, a one-entry holding register and sticky error flags.
module cfm_uart #(
  parameter int CLKS_PER_BIT   = 345,
  parameter int IDLE_STOP_BITS = 1
) (
  input  logic       clk_core,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clr,
  output logic       TX,
  input  logic       RX
);

  localparam int             CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_BIT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [1:0]     STOP_LAST = 2'(IDLE_STOP_BITS);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [1:0]    tx_stop_q, tx_stop_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_done_s, rx_ferr_set_s, rx_ovr_set_s;

  assign TX           = tx_line_q;
  assign tx_ready     = (tx_state_q == TX_IDLE);
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_overrun   = rx_ovr_q;
  assign rx_frame_err = rx_ferr_q;

  // TX next-state: line value is registered so it changes exactly on bit boundaries
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = CNT_ZERO;
        tx_bit_d  = 3'd0;
        tx_stop_d = 2'd0;
        tx_line_d = 1'b1;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_line_d  = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = CNT_ZERO;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = CNT_ZERO;
          if (tx_stop_q == STOP_LAST) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_stop_d = tx_stop_q + 2'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = 1'b1;
      end
    endcase
  end

  // TX state registers
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CNT_ZERO;
      tx_bit_q   <= 3'd0;
      tx_stop_q  <= 2'd0;
      tx_shift_q <= 8'h00;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // RX synchronizer; rx_prev_q gives the falling-edge reference for start detection
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX next-state: counter runs down to the mid-bit sample point
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_done_s     = 1'b0;
    rx_ferr_set_s = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_cnt_d   = HALF_BIT;
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_ZERO) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = BIT_LAST;
            rx_bit_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_ZERO) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_ZERO) begin
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            rx_done_s = 1'b1;
          end else begin
            rx_ferr_set_s = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Holding register and sticky flags; a set event beats err_clr in the same cycle
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_ovr_set_s = 1'b0;
    if (rx_done_s) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_set_s = 1'b1;
      end
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
    if (rx_ovr_set_s) begin
      rx_ovr_d = 1'b1;
    end else if (err_clr) begin
      rx_ovr_d = 1'b0;
    end else begin
      rx_ovr_d = rx_ovr_q;
    end
    if (rx_ferr_set_s) begin
      rx_ferr_d = 1'b1;
    end else if (err_clr) begin
      rx_ferr_d = 1'b0;
    end else begin
      rx_ferr_d = rx_ferr_q;
    end
  end

  // RX state and output registers
  always_ff @(posedge clk_core or negedge resetn) begin
    if (!resetn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CNT_ZERO;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

endmodule

// File: tb/tb_cfm_uart.sv
// Scoreboard bench for cfm_uart at 8 clocks/bit: received bytes are checked by a monitor
// against a queue of expected bytes; TX timing, flags and reset behaviour are checked directly.
module tb_cfm_uart;

  localparam int CPB = 8;

  logic       clk_core = 1'b0;
  logic       resetn;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       err_clr;
  logic       TX;
  logic       RX;
  logic       rx_drv;
  logic       loop_en;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;

  assign RX = loop_en ? TX : rx_drv;

  cfm_uart #(.CLKS_PER_BIT(CPB), .IDLE_STOP_BITS(0)) dut (
    .clk_core(clk_core), .resetn(resetn),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .err_clr(err_clr),
    .TX(TX), .RX(RX)
  );

  always #5 clk_core = ~clk_core;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Monitor: a new byte is presented when rx_valid rises or rx_data changes while valid
  always @(negedge clk_core) begin
    if (resetn && rx_valid && (!prev_v || rx_data != prev_d)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rx_unexpected: got %02h expected no byte", rx_data);
      end else begin
        check("rx_byte", rx_data, exp_q.pop_front());
      end
    end
    prev_v = rx_valid;
    prev_d = rx_data;
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int s = 0; s < 10; s++) begin
      rx_drv = frame[s];
      repeat (CPB) @(negedge clk_core);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_valid(input int maxc, input string name);
    for (int i = 0; i < maxc && !rx_valid; i++) @(negedge clk_core);
    check(name, 8'(rx_valid), 8'd1);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk_core);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk_core);
    err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] a5;
    logic       exp_tx;
    a5       = 8'hA5;
    resetn   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ack   = 1'b0;
    err_clr  = 1'b0;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;
    repeat (3) @(negedge clk_core);
    check("rst_tx", 8'(TX), 8'd1);
    check("rst_tx_ready", 8'(tx_ready), 8'd1);
    check("rst_rx_valid", 8'(rx_valid), 8'd0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overrun", 8'(rx_overrun), 8'd0);
    check("rst_frame_err", 8'(rx_frame_err), 8'd0);
    resetn = 1'b1;
    @(negedge clk_core);

    // TX 0xA5, with a competing byte offered while busy
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    check("tx_ready_idle", 8'(tx_ready), 8'd1);
    for (int k = 1; k <= 81; k++) begin
      @(negedge clk_core);
      if (k <= 8)       exp_tx = 1'b0;
      else if (k <= 72) exp_tx = a5[(k - 9) / 8];
      else              exp_tx = 1'b1;
      check("tx_line", 8'(TX), 8'(exp_tx));
      check("tx_ready", 8'(tx_ready), (k == 81) ? 8'd1 : 8'd0);
      if (k == 1) tx_valid = 1'b0;
      if (k == 5) begin
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
      end
      if (k == 70) tx_valid = 1'b0;
    end

    // RX 0x3C
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    wait_valid(8, "rx_3c_valid");
    check("rx_3c_ovr", 8'(rx_overrun), 8'd0);
    check("rx_3c_ferr", 8'(rx_frame_err), 8'd0);
    pulse_ack();
    check("rx_ack_clears", 8'(rx_valid), 8'd0);
    check("rx_ack_keeps_data", rx_data, 8'h3C);

    // Glitch on idle line
    rx_drv = 1'b0;
    repeat (2) @(negedge clk_core);
    rx_drv = 1'b1;
    repeat (20) @(negedge clk_core);
    check("glitch_valid", 8'(rx_valid), 8'd0);
    check("glitch_ovr", 8'(rx_overrun), 8'd0);
    check("glitch_ferr", 8'(rx_frame_err), 8'd0);

    // Overrun: second byte dropped
    exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (8) @(negedge clk_core);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_valid", 8'(rx_valid), 8'd1);
    check("ovr_flag", 8'(rx_overrun), 8'd1);
    pulse_ack();
    check("ovr_ack_valid", 8'(rx_valid), 8'd0);
    check("ovr_ack_keeps_flag", 8'(rx_overrun), 8'd1);
    pulse_clr();
    check("ovr_clr", 8'(rx_overrun), 8'd0);

    // Ack exactly on the completion cycle of the second byte (frames are 80 cycles apart)
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    fork
      begin
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
      end
      begin
        for (int i = 0; i < 120 && !rx_valid; i++) @(negedge clk_core);
        repeat (79) @(negedge clk_core);
        pulse_ack();
      end
    join
    repeat (8) @(negedge clk_core);
    check("ackc_data", rx_data, 8'h22);
    check("ackc_valid", 8'(rx_valid), 8'd1);
    check("ackc_ovr", 8'(rx_overrun), 8'd0);
    pulse_ack();

    // Frame error then a good frame
    send_rx(8'h55, 1'b0);
    repeat (8) @(negedge clk_core);
    check("ferr_flag", 8'(rx_frame_err), 8'd1);
    check("ferr_valid", 8'(rx_valid), 8'd0);
    check("ferr_ovr", 8'(rx_overrun), 8'd0);
    exp_q.push_back(8'h66);
    send_rx(8'h66, 1'b1);
    wait_valid(8, "ferr_next_valid");
    check("ferr_sticky", 8'(rx_frame_err), 8'd1);
    pulse_clr();
    check("ferr_clr", 8'(rx_frame_err), 8'd0);
    pulse_ack();

    // Reset during TX bit 3 and RX bit 5, with a byte still held
    exp_q.push_back(8'h77);
    send_rx(8'h77, 1'b1);
    wait_valid(8, "pre_rst_valid");
    fork
      send_rx(8'h99, 1'b1);
      begin
        repeat (16) @(negedge clk_core);
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        @(negedge clk_core);
        tx_valid = 1'b0;
      end
      begin
        repeat (53) @(negedge clk_core);
        check("pre_rst_tx_bit3", 8'(TX), 8'd0);
        check("pre_rst_tx_ready", 8'(tx_ready), 8'd0);
        resetn = 1'b0;
        #1;
        check("mid_rst_tx", 8'(TX), 8'd1);
        check("mid_rst_tx_ready", 8'(tx_ready), 8'd1);
        check("mid_rst_rx_valid", 8'(rx_valid), 8'd0);
        check("mid_rst_rx_data", rx_data, 8'h00);
        repeat (32) @(negedge clk_core);
      end
    join
    resetn = 1'b1;
    repeat (4) @(negedge clk_core);
    check("post_rst_tx", 8'(TX), 8'd1);
    check("post_rst_valid", 8'(rx_valid), 8'd0);

    // Loopback
    loop_en = 1'b1;
    exp_q.push_back(8'hC3);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk_core);
    tx_valid = 1'b0;
    wait_valid(120, "loop_valid");
    check("loop_ovr", 8'(rx_overrun), 8'd0);
    check("loop_ferr", 8'(rx_frame_err), 8'd0);
    pulse_ack();
    repeat (4) @(negedge clk_core);

    check("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
